seq_detect_fsm: RTL and testbench
=================================

// Module: seq_detect_fsm
// PURPOSE
//  Parametrised serial pattern detector: generalised successor of the fixed 4-state x/y FSM.
//  Tracks match progress against a PATTERN_W-bit pattern on a 1-bit input qualified by en.
//  Supports overlapping and non-overlapping detection, a saturating match counter and sync clear.
//  Sits between a serial input sampler and status/interrupt logic in the same clock domain.
// PARAMETERS
//  PATTERN_W  4        pattern length in bits, 2..16
//  PATTERN    4'b1011  pattern; MSB is the first bit received
//  OVERLAP    1        1 = a match may reuse its suffix; 0 = restart from empty after a match
//  CNT_W      8        match counter width, >=1
// PORTS
//  clk        in   1                  rising-edge clock
//  rst_n      in   1                  asynchronous active-low reset
//  en         in   1                  din valid this cycle
//  din        in   1                  serial data bit
//  clr        in   1                  synchronous clear of progress, counter and sat flag
//  match      out  1                  one-cycle pulse: pattern completed on previous sampled bit
//  progress   out  $clog2(PATTERN_W)  matched-prefix length, 0..PATTERN_W-1
//  match_cnt  out  CNT_W              saturating count of matches
//  cnt_sat    out  1                  sticky; set when match_cnt reaches all-ones
// BEHAVIOUR
//  Reset (rst_n low, async): progress=0, match=0, match_cnt=0, cnt_sat=0. All outputs registered.
//  State is progress P. Each rising edge with en=1:
//   - c = P+1 if din == PATTERN[PATTERN_W-1-P], else c = longest k<=P such that the last k bits
//     received (incl. din) equal PATTERN[PATTERN_W-1 -: k]. Use a precomputed failure function.
//   - c == PATTERN_W (match): match<=1. P<=B when OVERLAP=1, where B is the longest proper border
//     of PATTERN. P<=0 when OVERLAP=0.
//   - else: match<=0, P<=c.
//  en=0: P holds, match<=0, counter holds.
//  Latency: match is high for exactly the one cycle after the edge that samples the last pattern bit.
//  Counter: increments on every edge where match is set; stops at 2^CNT_W-1 (no wrap).
//   cnt_sat <= 1 on the same edge match_cnt becomes all-ones; held until clr or reset.
//  clr=1 has priority over en: P<=0, match<=0, match_cnt<=0, cnt_sat<=0. din is ignored that cycle.
//  Back-to-back matches (OVERLAP=1, e.g. pattern 1111) produce match high on consecutive cycles,
//   with the counter incremented on each.
//  Reset asserted mid-pattern: all state clears immediately. Detection restarts from P=0 after
//   rst_n deasserts.
//  Elaboration check: PATTERN_W outside 2..16 -> $error.
// STRUCTURE
//  Package seq_fsm_pkg: function border_len(pattern,width) and failure-table function fail_next();
//   constants for min/max PATTERN_W.
//  Top: failure table as localparam array, progress register, next-state logic.
//  One sub-module: sat_counter #(W) (clk, rst_n, clr, inc, cnt, sat), instantiated for
//   match_cnt/cnt_sat.
// TESTING
//  T1 reset: rst_n=0 while driving en/din -> all outputs 0. Release -> progress=0.
//  T2 overlap: PATTERN=1011, OVERLAP=1, en=1, din=1,0,1,1,0,1,1 -> match after bits 4 and 7;
//     match_cnt=2; progress=1 after each match.
//  T3 non-overlap: same stream, OVERLAP=0 -> match only after bit 4; progress=1 after bit 7;
//     match_cnt=1.
//  T4 en gaps/failure: en toggling with din=1,0,(en=0),1,1 -> match after 4th valid bit.
//     Stream 1,0,1,0,1,1 -> progress 1,2,3,2,3 then match.
//  T5 saturation: CNT_W=2, PATTERN=11, OVERLAP=1, 6 ones -> match_cnt stops at 3, cnt_sat=1
//     on 3rd match. clr -> cnt=0, sat=0.
//  T6 clr vs en, async reset: clr=1 with completing bit -> no match, progress=0.
//     rst_n pulsed low mid-pattern between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/seq_fsm_pkg.sv
// Shared helpers for the serial pattern detector:
// border length and failure-table generation.
package seq_fsm_pkg;

  localparam int PW_MIN    = 2;
  localparam int PW_MAX    = 16;
  localparam int ST_W      = 5;
  localparam int TBL_IDX_W = $clog2(2 * PW_MAX);

  typedef logic [2*PW_MAX-1:0][ST_W-1:0] fail_tbl_t;

  function automatic logic pbit(
    input logic [PW_MAX-1:0] pat,
    input int                i
  );
    logic [PW_MAX-1:0] s;
    s = pat >> i;
    return s[0];
  endfunction

  function automatic int border_len(
    input logic [PW_MAX-1:0] pat,
    input int                w
  );
    logic ok;
    for (int k = w - 1; k > 0; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pbit(pat, w-1-i) != pbit(pat, k-1-i))
          ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  // Longest prefix that is a suffix of (prefix[p] . b).
  function automatic int fail_next(
    input logic [PW_MAX-1:0] pat,
    input int                w,
    input int                p,
    input logic              b
  );
    logic ok;
    logic sb;
    int   pos;
    for (int k = p + 1; k > 0; k--) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        pos = p + 1 - k + i;
        sb  = (pos == p) ? b : pbit(pat, w-1-pos);
        if (sb != pbit(pat, w-1-i))
          ok = 1'b0;
      end
      if (ok) return k;
    end
    return 0;
  endfunction

  function automatic fail_tbl_t fail_table(
    input logic [PW_MAX-1:0] pat,
    input int                w
  );
    fail_tbl_t t;
    t = '0;
    for (int p = 0; p < w; p++) begin
      for (int b = 0; b < 2; b++) begin
        t |= fail_tbl_t'(ST_W'(fail_next(pat, w, p, 1'(b))))
             << (ST_W * (2*p + b));
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/seq_detect_fsm_sat_counter.sv
// Saturating event counter with sticky
// saturation flag and synchronous clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + 1'b1;
      if (cnt == MAX - 1'b1)
        sat <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector driven by a
// precomputed failure table (KMP style).
module seq_detect_fsm
  import seq_fsm_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         din,
  input  logic                         clr,
  output logic                         match,
  output logic [$clog2(PATTERN_W)-1:0] progress,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         cnt_sat
);

  localparam int PW = $clog2(PATTERN_W);

  localparam logic [PW_MAX-1:0] PAT_EXT =
    PW_MAX'(PATTERN);

  localparam fail_tbl_t FAIL_TBL =
    fail_table(PAT_EXT, PATTERN_W);

  localparam logic [PW-1:0] BORDER =
    PW'(border_len(PAT_EXT, PATTERN_W));

  localparam logic [ST_W-1:0] FULL =
    ST_W'(PATTERN_W);

  if (PATTERN_W < PW_MIN || PATTERN_W > PW_MAX) begin : g_bad_w
    $error("seq_detect_fsm: PATTERN_W out of range");
  end

  logic [PW-1:0]        prog_q;
  logic [PW-1:0]        prog_d;
  logic                 match_q;
  logic                 match_d;
  logic                 hit;
  logic [TBL_IDX_W-1:0] idx;
  logic [ST_W-1:0]      cand;

  assign idx  = TBL_IDX_W'({prog_q, din});
  assign cand = FAIL_TBL[idx];

  // clr wins over en; a full match folds back to the border
  always_comb begin
    hit     = 1'b0;
    prog_d  = prog_q;
    match_d = 1'b0;
    if (clr) begin
      prog_d = '0;
    end else if (en) begin
      if (cand == FULL) begin
        hit    = 1'b1;
        prog_d = OVERLAP ? BORDER : '0;
      end else begin
        prog_d = cand[PW-1:0];
      end
    end
    match_d = hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_q  <= '0;
      match_q <= 1'b0;
    end else begin
      prog_q  <= prog_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (hit),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign match    = match_q;
  assign progress = prog_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Randomised + directed bench for seq_detect_fsm,
// three configurations against a history-based model.
module tb_seq_detect_fsm;

  logic clk;
  logic rst_n;
  logic en;
  logic din;
  logic clr;

  logic       m_a, m_b, m_c;
  logic [1:0] p_a, p_b;
  logic [0:0] p_c;
  logic [7:0] c_a, c_b;
  logic [1:0] c_c;
  logic       s_a, s_b, s_c;

  seq_detect_fsm #(
    .PATTERN_W (4), .PATTERN (4'b1011),
    .OVERLAP (1'b1), .CNT_W (8)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .en (en), .din (din),
    .clr (clr), .match (m_a), .progress (p_a),
    .match_cnt (c_a), .cnt_sat (s_a)
  );

  seq_detect_fsm #(
    .PATTERN_W (4), .PATTERN (4'b1011),
    .OVERLAP (1'b0), .CNT_W (8)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .en (en), .din (din),
    .clr (clr), .match (m_b), .progress (p_b),
    .match_cnt (c_b), .cnt_sat (s_b)
  );

  seq_detect_fsm #(
    .PATTERN_W (2), .PATTERN (2'b11),
    .OVERLAP (1'b1), .CNT_W (2)
  ) u_c (
    .clk (clk), .rst_n (rst_n), .en (en), .din (din),
    .clr (clr), .match (m_c), .progress (p_c),
    .match_cnt (c_c), .cnt_sat (s_c)
  );

  logic       g_match [3];
  logic [3:0] g_prog  [3];
  logic [7:0] g_cnt   [3];
  logic       g_sat   [3];

  assign g_match[0] = m_a;
  assign g_match[1] = m_b;
  assign g_match[2] = m_c;
  assign g_prog[0]  = 4'(p_a);
  assign g_prog[1]  = 4'(p_b);
  assign g_prog[2]  = 4'(p_c);
  assign g_cnt[0]   = c_a;
  assign g_cnt[1]   = c_b;
  assign g_cnt[2]   = 8'(c_c);
  assign g_sat[0]   = s_a;
  assign g_sat[1]   = s_b;
  assign g_sat[2]   = s_c;

  // reference model: raw bit history, newest bit at LSB
  int          pw   [3] = '{4, 4, 2};
  longint      pat  [3] = '{64'hB, 64'hB, 64'h3};
  bit          ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int          cmax [3] = '{255, 255, 3};
  string       nm   [3] = '{"A", "B", "C"};

  longint unsigned hist    [3];
  int              hlen    [3];
  int              m_prog  [3];
  bit              m_match [3];
  int              m_cnt   [3];
  bit              m_sat   [3];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // last k received bits equal the first k pattern bits
  function automatic bit sfx(int i, int k);
    longint unsigned mask;
    mask = (k == 0) ? 64'd0 : ((64'd1 << k) - 64'd1);
    return hlen[i] >= k &&
      ((hist[i] & mask) ==
       ((64'(pat[i]) >> (pw[i] - k)) & mask));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i]    = 0;
      hlen[i]    = 0;
      m_prog[i]  = 0;
      m_match[i] = 1'b0;
      m_cnt[i]   = 0;
      m_sat[i]   = 1'b0;
    end
  endtask

  task automatic model_step(bit e, bit d, bit c);
    if (!rst_n || c) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      m_match[i] = 1'b0;
      if (e) begin
        hist[i] = (hist[i] << 1) | 64'(d);
        if (hlen[i] < 64) hlen[i]++;
        m_match[i] = sfx(i, pw[i]);
        if (m_match[i]) begin
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          if (m_cnt[i] == cmax[i]) m_sat[i] = 1'b1;
          if (!ovl[i]) hlen[i] = 0;
        end
        m_prog[i] = 0;
        for (int k = pw[i] - 1; k > 0; k--) begin
          if (m_prog[i] == 0 && sfx(i, k))
            m_prog[i] = k;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk({nm[i], ".match"}, 32'(g_match[i]), 32'(m_match[i]));
      chk({nm[i], ".prog"},  32'(g_prog[i]),  32'(m_prog[i]));
      chk({nm[i], ".cnt"},   32'(g_cnt[i]),   32'(m_cnt[i]));
      chk({nm[i], ".sat"},   32'(g_sat[i]),   32'(m_sat[i]));
    end
  endtask

  task automatic cycle(bit e, bit d, bit c);
    en  = e;
    din = d;
    clr = c;
    @(posedge clk);
    #1;
    model_step(e, d, c);
    check_all();
  endtask

  logic [6:0] s7;
  logic [5:0] s6;
  int         ep [5] = '{1, 2, 3, 2, 3};

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    clr   = 1'b0;
    model_reset();

    // reset held while inputs toggle
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    chk("T1.cnt", 32'(g_cnt[0]), 0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
    chk("T1.prog", 32'(g_prog[0]), 0);

    // overlap (A) vs non-overlap (B)
    s7 = 7'b1011011;
    for (int j = 6; j >= 0; j--) begin
      cycle(1'b1, s7[j], 1'b0);
      if (j == 3) begin
        chk("T2.m4", 32'(g_match[0]), 1);
        chk("T2.p4", 32'(g_prog[0]), 1);
        chk("T3.m4", 32'(g_match[1]), 1);
        chk("T3.p4", 32'(g_prog[1]), 0);
      end
      if (j == 0) begin
        chk("T2.m7", 32'(g_match[0]), 1);
        chk("T2.p7", 32'(g_prog[0]), 1);
        chk("T2.cnt", 32'(g_cnt[0]), 2);
        chk("T3.m7", 32'(g_match[1]), 0);
        chk("T3.p7", 32'(g_prog[1]), 1);
        chk("T3.cnt", 32'(g_cnt[1]), 1);
      end
    end

    // en gaps
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("T4.hold", 32'(g_prog[0]), 2);
    cycle(1'b1, 1'b1, 1'b0);
    chk("T4.nom", 32'(g_match[0]), 0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("T4.m", 32'(g_match[0]), 1);

    // failure transitions
    cycle(1'b0, 1'b0, 1'b1);
    s6 = 6'b101011;
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, s6[5-j], 1'b0);
      if (j < 5) chk("T4.prog", 32'(g_prog[0]), 32'(ep[j]));
      else       chk("T4.m6", 32'(g_match[0]), 1);
    end

    // saturation on C (pattern 11, 2-bit counter)
    cycle(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      cycle(1'b1, 1'b1, 1'b0);
      chk("T5.cnt", 32'(g_cnt[2]), (j <= 3) ? 32'(j) : 32'd3);
      chk("T5.sat", 32'(g_sat[2]), (j >= 3) ? 32'd1 : 32'd0);
      if (j >= 1) chk("T5.btb", 32'(g_match[2]), 1);
    end
    cycle(1'b0, 1'b0, 1'b1);
    chk("T5.clrc", 32'(g_cnt[2]), 0);
    chk("T5.clrs", 32'(g_sat[2]), 0);

    // clr beats a completing bit
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("T6.m", 32'(g_match[0]), 0);
    chk("T6.p", 32'(g_prog[0]), 0);

    // async reset between edges
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("T6.pre", 32'(g_prog[0]), 2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("T6.rcnt", 32'(g_cnt[0]), 0);
    chk("T6.rp", 32'(g_prog[0]), 0);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);
    chk("T6.restart", 32'(g_prog[0]), 1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
